lsu_mem_stage: RTL and testbench
================================

Name: lsu_mem_stage

Overview:
- Load/store unit in the MEM stage, directly downstream of the 32-bit ALU.
- Takes the ALU result as the effective address, plus rs2 store data and the funct3 access type.
- Drives a req/gnt/rvalid data-memory port. Returns sign- or zero-extended load data to write-back.
- Multi-cycle, one transaction in flight; stalls the EX stage via `ex_ready`.

Parameters:
- WIDTH, 32, datapath width. Only 32 is supported; 4 byte lanes.
- ADDR_W, 32, memory address width.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  EX presents a memory op this cycle
- ex_ready  out  1  LSU can accept an op (IDLE only)
- ex_we  in  1  1=store, 0=load
- ex_funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only)
- ex_addr  in  WIDTH  effective address (ALU alu_out)
- ex_wdata  in  WIDTH  store data (rs2)
- ex_rd  in  5  load destination register
- flush  in  1  kill current op (branch/trap)
- mem_req  out  1  memory request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word-aligned address, bits[1:0]=0
- mem_be  out  4  byte enables
- mem_wdata  out  WIDTH  lane-shifted store data
- mem_gnt  in  1  request accepted
- mem_rvalid  in  1  read data valid
- mem_rdata  in  WIDTH  read data
- wb_valid  out  1  one-cycle load result pulse
- wb_rd  out  5  destination register
- wb_data  out  WIDTH  extended load data
- misalign  out  1  one-cycle misaligned-access pulse
- busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0): state IDLE. `mem_req`, `mem_we`, `wb_valid`, `misalign` = 0. `mem_addr`, `mem_be`, `mem_wdata`, `wb_rd`, `wb_data` = 0. `ex_ready` = 1 after reset release.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE:
  - Accept when ex_valid && ex_ready.
  - Register addr/be/wdata/we/funct3/rd; go to REQ.
  - `flush` in the accept cycle blocks acceptance.
- REQ:
  - `mem_req`=1; outputs held stable until `mem_gnt`.
  - gnt with store: go to IDLE (no write-back).
  - gnt with load: go to WAIT.
  - `flush` before gnt: drop `mem_req` next cycle, go to IDLE.
  - `mem_rvalid` ignored in REQ.
- WAIT:
  - On `mem_rvalid`: capture formatted data, go to RESP.
  - `flush` in WAIT sets a kill flag. The rvalid is still consumed, then go to IDLE with no wb.
- RESP:
  - `wb_valid`=1 for exactly one cycle, then IDLE.
  - rd=0 still pulses `wb_valid`; the register file discards it.
- Best-case load latency: accept T0, req+gnt T1, rvalid T2, `wb_valid` T3. Store: accept T0, gnt T1, ready again T2.
- Byte enables:
  - B: 0001<<addr[1:0].
  - H: 0011<<addr[1:0].
  - W: 1111.
  - Store data: B replicated to all 4 lanes, H replicated to both halves.
- Load extract:
  - byte lane = addr[1:0]; half lane = addr[1].
  - B/H sign-extend; BU/HU zero-extend; W passes through.
- Misaligned access: H with addr[0]=1, or W with addr[1:0]!=0. Handling is set by the optional feature below.
- Reset mid-transaction: return to IDLE. Any later stray `mem_rvalid` is ignored in IDLE.

Optional Feature:
- Macro: LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned accept pulses `misalign` for one cycle on the cycle after acceptance.
  - No memory request is issued; the unit stays IDLE.
- Undefined:
  - The address is forced aligned down (H clears bit0, W clears bits[1:0]) and the access is performed.
  - `misalign` is tied to 0.

Decomposition:
- lsu_pkg:
  - funct3 encodings (LSU_B, LSU_H, LSU_W, LSU_BU, LSU_HU).
  - FSM state enum.
  - Byte-enable base constants.
- Sub-module lsu_load_align: combinational lane select and sign/zero extension from (rdata, addr[1:0], funct3). Reused by any future cache fill path.

Test Plan:
- LW addr 0x100, gnt immediate, rdata 0xDEADBEEF next cycle -> `mem_addr` 0x100, `mem_be` 1111, `wb_valid` at T3, `wb_data` 0xDEADBEEF.
- LB addr 0x103, rdata 0x80FF_0000 -> `wb_data` 0xFFFF_FF80. LBU same -> 0x0000_0080. LH addr 0x102 -> 0xFFFF_80FF.
- SB addr 0x201 wdata 0x1234_56AB, gnt delayed 3 cycles -> `mem_req` held 4 cycles, `mem_be` 0010, `mem_wdata` 0xABAB_ABAB, `ex_ready` low until gnt+1, no `wb_valid`.
- LW accepted, `flush` in WAIT, rvalid 2 cycles later -> no `wb_valid`, `ex_ready` returns 1 the cycle after rvalid.
- SW addr 0x102: with LSU_MISALIGN_TRAP_EN -> one-cycle `misalign`, `mem_req` never asserted. Without -> `mem_addr` 0x100, `mem_be` 1111, `misalign` 0.
- rst_n low while in WAIT -> all outputs 0 immediately (async), IDLE; later stray rvalid produces no `wb_valid`.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: shared encodings, FSM states and lane helpers for the load/store unit
package lsu_pkg;
  localparam logic [2:0] LSU_B  = 3'b000;
  localparam logic [2:0] LSU_H  = 3'b001;
  localparam logic [2:0] LSU_W  = 3'b010;
  localparam logic [2:0] LSU_BU = 3'b100;
  localparam logic [2:0] LSU_HU = 3'b101;
  localparam logic [3:0] BE_B = 4'b0001;
  localparam logic [3:0] BE_H = 4'b0011;
  localparam logic [3:0] BE_W = 4'b1111;
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} lsu_state_t;
  // funct3[1] marks a word access, funct3[0] a halfword, neither a byte
  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    return f3[1] ? (off != 2'b00) : (f3[0] & off[0]);
  endfunction
  function automatic logic [1:0] align_off(input logic [2:0] f3, input logic [1:0] off);
    return f3[1] ? 2'b00 : f3[0] ? {off[1], 1'b0} : off;
  endfunction
  function automatic logic [3:0] be_base(input logic [2:0] f3);
    return f3[1] ? BE_W : f3[0] ? BE_H : BE_B;
  endfunction
endpackage

// File: rtl/lsu_load_align.sv
// lsu_load_align: selects the addressed byte/half lane of a read word and sign/zero extends it
// Ports: rdata (memory word), off (aligned byte offset), funct3 (access type), data (write-back value)
module lsu_load_align (
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  b;
  logic [15:0] h;
  logic        sx;
  always_comb begin
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    sx = ~funct3[2];
    data = funct3[1] ? rdata : funct3[0] ? {{16{sx & h[15]}}, h} : {{24{sx & b[7]}}, b};
  end
endmodule

// File: rtl/lsu_mem_stage.sv
// lsu_mem_stage: MEM-stage load/store unit driving a req/gnt/rvalid data port, one op in flight
// Ports: ex_* op from EX with ex_ready backpressure; flush kills the op; mem_* data-memory port;
// wb_* one-cycle load result; misalign pulse; busy while not idle.
// Option LSU_MISALIGN_TRAP_EN: misaligned ops pulse misalign and are dropped; otherwise they are aligned down.
module lsu_mem_stage
  import lsu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic              ex_we,
  input  logic [2:0]        ex_funct3,
  input  logic [WIDTH-1:0]  ex_addr,
  input  logic [WIDTH-1:0]  ex_wdata,
  input  logic [4:0]        ex_rd,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WIDTH-1:0]  mem_rdata,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [WIDTH-1:0]  wb_data,
  output logic              misalign,
  output logic              busy
);
  lsu_state_t       state, state_nx;
  logic             accept, take, kill;
  logic [1:0]       off_q, off_a;
  logic [2:0]       f3_q;
  logic [WIDTH-1:0] ld_data;
  assign ex_ready = state == IDLE;
  assign busy     = state != IDLE;
  assign mem_req  = state == REQ;
  assign wb_valid = state == RESP;
  assign accept   = ex_valid && (state == IDLE) && !flush;
  assign off_a    = align_off(ex_funct3, ex_addr[1:0]);
`ifdef LSU_MISALIGN_TRAP_EN
  assign take = accept && !misaligned(ex_funct3, ex_addr[1:0]);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign <= 1'b0;
    else misalign <= accept && misaligned(ex_funct3, ex_addr[1:0]);
  end
`else
  assign take     = accept;
  assign misalign = 1'b0;
`endif
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  // A grant always completes the handshake; flush only aborts a request not yet granted
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = take ? REQ : IDLE;
      REQ:     state_nx = mem_gnt ? (mem_we ? IDLE : WAIT) : flush ? IDLE : REQ;
      WAIT:    state_nx = mem_rvalid ? ((kill || flush) ? IDLE : RESP) : WAIT;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_rd     <= '0;
      wb_data   <= '0;
      off_q     <= '0;
      f3_q      <= '0;
      kill      <= 1'b0;
    end else begin
      if (take) begin
        mem_we    <= ex_we;
        mem_addr  <= ADDR_W'({ex_addr[WIDTH-1:2], 2'b00});
        mem_be    <= be_base(ex_funct3) << off_a;
        mem_wdata <= ex_funct3[1] ? ex_wdata : ex_funct3[0] ? {2{ex_wdata[15:0]}} : {4{ex_wdata[7:0]}};
        wb_rd     <= ex_rd;
        off_q     <= off_a;
        f3_q      <= ex_funct3;
        kill      <= 1'b0;
      end else if (flush && (state == WAIT || (state == REQ && mem_gnt))) begin
        kill <= 1'b1;
      end
      if (state == WAIT && mem_rvalid && !kill && !flush) wb_data <= ld_data;
    end
  end
  lsu_load_align u_align (
    .rdata  (mem_rdata),
    .off    (off_q),
    .funct3 (f3_q),
    .data   (ld_data)
  );
endmodule

// File: tb/tb_lsu_mem_stage.sv
// tb_lsu_mem_stage: table-driven and scripted checks of lsu_mem_stage with a write-back scoreboard
module tb_lsu_mem_stage;
  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ex_valid = 0, ex_we = 0, flush = 0, mem_gnt = 0, mem_rvalid = 0;
  logic [2:0]  ex_funct3 = 0;
  logic [31:0] ex_addr = 0, ex_wdata = 0, mem_rdata = 0;
  logic [4:0]  ex_rd = 0;
  logic        ex_ready, mem_req, mem_we, wb_valid, misalign, busy;
  logic [31:0] mem_addr, mem_wdata, wb_data;
  logic [3:0]  mem_be;
  logic [4:0]  wb_rd;
  int checks = 0;
  int errors = 0;
  logic [36:0] sb[$];
  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    logic [31:0] eaddr;
    logic [3:0]  ebe;
    logic [31:0] ewdata;
    logic [31:0] ewb;
  } vec_t;
  vec_t tbl[$];

  lsu_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_we(ex_we),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd), .flush(flush),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .misalign(misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", n, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && wb_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL wb_unexpected got rd %0d data %h expected no write-back at %0t", wb_rd, wb_data, $time);
      end else begin
        logic [36:0] e;
        e = sb.pop_front();
        if ({wb_rd, wb_data} !== e) begin
          errors++;
          $display("FAIL wb_result got rd %0d data %h expected rd %0d data %h", wb_rd, wb_data, e[36:32], e[31:0]);
        end
      end
    end
  end

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd, input logic [4:0] rd);
    ex_valid = 1; ex_we = we; ex_funct3 = f3; ex_addr = a; ex_wdata = wd; ex_rd = rd;
  endtask

  task automatic run_op(input vec_t v, input int gd);
    @(negedge clk);
    chk("ready_idle", ex_ready, 1);
    issue(v.we, v.f3, v.addr, v.wdata, v.rd);
    if (!v.we) sb.push_back({v.rd, v.ewb});
    @(negedge clk);
    ex_valid = 0;
    for (int i = 0; i <= gd; i++) begin
      chk("req_held", mem_req, 1);
      chk("ready_low", ex_ready, 0);
      chk("mem_addr", mem_addr, v.eaddr);
      chk("mem_be", mem_be, v.ebe);
      chk("mem_we", mem_we, v.we);
      if (v.we) chk("mem_wdata", mem_wdata, v.ewdata);
      mem_gnt = (i == gd);
      @(negedge clk);
    end
    mem_gnt = 0;
    chk("req_drop", mem_req, 0);
    if (v.we) chk("ready_after_store", ex_ready, 1);
    else begin
      mem_rvalid = 1; mem_rdata = v.rdata;
      @(negedge clk);
      mem_rvalid = 0; mem_rdata = 0;
      chk("wb_pulse", wb_valid, 1);
      @(negedge clk);
      chk("wb_one_cycle", wb_valid, 0);
      chk("ready_after_load", ex_ready, 1);
    end
  endtask

  initial begin
    vec_t sv;
    tbl.push_back('{0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 5'd1, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF});
    tbl.push_back('{0, 3'b000, 32'h103, 32'h0, 32'h80FF0000, 5'd2, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80});
    tbl.push_back('{0, 3'b100, 32'h103, 32'h0, 32'h80FF0000, 5'd3, 32'h100, 4'b1000, 32'h0, 32'h00000080});
    tbl.push_back('{0, 3'b001, 32'h102, 32'h0, 32'h80FF0000, 5'd4, 32'h100, 4'b1100, 32'h0, 32'hFFFF80FF});
    tbl.push_back('{0, 3'b101, 32'h100, 32'h0, 32'h12348001, 5'd5, 32'h100, 4'b0011, 32'h0, 32'h00008001});
    tbl.push_back('{0, 3'b000, 32'h101, 32'h0, 32'h00007F00, 5'd6, 32'h100, 4'b0010, 32'h0, 32'h0000007F});
    tbl.push_back('{0, 3'b010, 32'h480, 32'h0, 32'h0BADF00D, 5'd0, 32'h480, 4'b1111, 32'h0, 32'h0BADF00D});
    tbl.push_back('{1, 3'b010, 32'h300, 32'hCAFEF00D, 32'h0, 5'd0, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0});
    tbl.push_back('{1, 3'b001, 32'h302, 32'h0000BEEF, 32'h0, 5'd0, 32'h300, 4'b1100, 32'hBEEFBEEF, 32'h0});
    tbl.push_back('{1, 3'b000, 32'h200, 32'h00000055, 32'h0, 5'd0, 32'h200, 4'b0001, 32'h55555555, 32'h0});
`ifndef LSU_MISALIGN_TRAP_EN
    tbl.push_back('{1, 3'b010, 32'h102, 32'hA1B2C3D4, 32'h0, 5'd0, 32'h100, 4'b1111, 32'hA1B2C3D4, 32'h0});
    tbl.push_back('{0, 3'b001, 32'h103, 32'h0, 32'hA5B60000, 5'd9, 32'h100, 4'b1100, 32'h0, 32'hFFFFA5B6});
`endif
    #2 rst_n = 0;
    @(negedge clk);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_misalign", misalign, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_be", mem_be, 0);
    chk("rst_wb_data", wb_data, 0);
    rst_n = 1;
    @(negedge clk);
    chk("ready_after_reset", ex_ready, 1);
    chk("busy_after_reset", busy, 0);
    foreach (tbl[i]) begin
      run_op(tbl[i], i % 3);
      chk("misalign_quiet", misalign, 0);
    end
    sv = '{1, 3'b000, 32'h201, 32'h123456AB, 32'h0, 5'd0, 32'h200, 4'b0010, 32'hABABABAB, 32'h0};
    run_op(sv, 3);
    @(negedge clk);
    issue(0, 3'b010, 32'h500, 0, 5'd8);
    flush = 1;
    @(negedge clk);
    ex_valid = 0; flush = 0;
    chk("flush_accept_busy", busy, 0);
    chk("flush_accept_req", mem_req, 0);
    issue(1, 3'b010, 32'h600, 32'h77, 5'd0);
    @(negedge clk);
    ex_valid = 0;
    chk("flush_req_req", mem_req, 1);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_req_drop", mem_req, 0);
    chk("flush_req_ready", ex_ready, 1);
    issue(0, 3'b010, 32'h400, 0, 5'd7);
    @(negedge clk);
    ex_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0; flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_wait_ready", ex_ready, 0);
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h11111111;
    chk("flush_rv_ready", ex_ready, 0);
    @(negedge clk);
    mem_rvalid = 0;
    chk("flush_done_ready", ex_ready, 1);
    chk("flush_no_wb", wb_valid, 0);
    @(negedge clk);
    chk("flush_no_wb2", wb_valid, 0);
`ifdef LSU_MISALIGN_TRAP_EN
    issue(1, 3'b010, 32'h102, 32'h5A5A5A5A, 5'd0);
    @(negedge clk);
    ex_valid = 0;
    chk("trap_pulse", misalign, 1);
    chk("trap_no_req", mem_req, 0);
    chk("trap_idle", ex_ready, 1);
    @(negedge clk);
    chk("trap_pulse_end", misalign, 0);
    chk("trap_no_req2", mem_req, 0);
`endif
    issue(0, 3'b010, 32'h700, 0, 5'd12);
    @(negedge clk);
    ex_valid = 0; mem_gnt = 1;
    @(negedge clk);
    mem_gnt = 0;
    chk("pre_reset_wait", busy, 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_mem_req", mem_req, 0);
    chk("arst_mem_we", mem_we, 0);
    chk("arst_mem_addr", mem_addr, 0);
    chk("arst_mem_be", mem_be, 0);
    chk("arst_mem_wdata", mem_wdata, 0);
    chk("arst_wb_rd", wb_rd, 0);
    chk("arst_wb_data", wb_data, 0);
    chk("arst_wb_valid", wb_valid, 0);
    chk("arst_misalign", misalign, 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    mem_rvalid = 1; mem_rdata = 32'h22222222;
    @(negedge clk);
    mem_rvalid = 0;
    chk("stray_rv_no_wb", wb_valid, 0);
    chk("stray_rv_idle", ex_ready, 1);
    @(negedge clk);
    chk("stray_rv_no_wb2", wb_valid, 0);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
